stage_sequencer: RTL and testbench



---
 rtl/stage_sequencer_if.sv | 59 +++++
 rtl/stage_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg / stage_sequencer_if
//
// Purpose : Shared types for the multi-cycle RV32I core stage sequencing, and
//           the handshake interface between state_machine and stage_sequencer.
//
// Interface signals:
//   now_state     state_machine -> sequencer   current core stage
//   now_state_d1  state_machine -> sequencer   now_state delayed one cycle
//   next_state    state_machine -> sequencer   stage taken on state_finish
//   state_finish  sequencer -> state_machine   one-cycle stage-done pulse
//   opcode        sequencer -> state_machine   opcode of the current instr
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_I_TYPE = 7'b0010011;
    localparam opcode_t OP_R_TYPE = 7'b0110011;
    localparam opcode_t OP_LUI    = 7'b0110111;

endpackage

interface stage_sequencer_if;

    stage_sequencer_pkg::state_t  now_state;
    stage_sequencer_pkg::state_t  now_state_d1;
    stage_sequencer_pkg::state_t  next_state;
    logic                         state_finish;
    stage_sequencer_pkg::opcode_t opcode;

    modport master (
        output state_finish,
        output opcode,
        input  now_state,
        input  now_state_d1,
        input  next_state
    );

    modport slave (
        input  state_finish,
        input  opcode,
        output now_state,
        output now_state_d1,
        output next_state
    );

endinterface

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose : Decides when each core stage is complete. Runs the instruction
//           memory handshake in FETCH, latches the opcode in DECODE, waits out
//           execute stalls and runs the data memory handshake in MEMORY.
//           A memory that never answers trips a timeout into a sticky fault.
//
// Internal FSM:
//   state      | meaning
//   WAIT_ENTRY | idle until state_machine enters a new stage
//   ACTIVE     | working on the current stage (request / stall / latch)
//   FINISH     | state_finish pulse, one cycle
//   HALT       | fault (IDLE entry or timeout), left only by rst
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   sm_if (master)      state_finish/opcode out, now/d1/next state in
//   o_imem_req          instruction fetch request (level)
//   i_imem_ready/rdata  instruction response and word
//   o_instr             latched instruction
//   o_dmem_req/we       data access request, 1 = store
//   i_dmem_ready/rdata  data response and load word
//   o_load_data         latched load data
//   i_exec_stall        datapath EXECUTE not finished
//   o_bus_err           sticky fault flag
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    stage_sequencer_if.master        sm_if,
    output logic                     o_imem_req,
    input  logic                     i_imem_ready,
    input  logic [31:0]              i_imem_rdata,
    output logic [31:0]              o_instr,
    output logic                     o_dmem_req,
    output logic                     o_dmem_we,
    input  logic                     i_dmem_ready,
    input  logic [31:0]              i_dmem_rdata,
    output logic [31:0]              o_load_data,
    input  logic                     i_exec_stall,
    output logic                     o_bus_err
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        WAIT_ENTRY,
        ACTIVE,
        FINISH,
        HALT
    } seq_state_t;

    seq_state_t    r_seq;
    logic [CW-1:0] r_cnt;
    logic          r_state_finish;
    logic          r_imem_req;
    logic          r_dmem_req;
    logic          r_dmem_we;
    logic          r_bus_err;
    opcode_t       r_opcode;
    logic [31:0]   r_instr;
    logic [31:0]   r_load_data;

    logic          w_entry;
    logic          w_is_load;
    logic          w_is_store;
    logic [CW-1:0] w_cnt_next;
    logic          w_limit_hit;
    logic          w_unused_next;

    assign w_entry     = (sm_if.now_state != sm_if.now_state_d1);
    assign w_is_load   = (r_opcode == OP_LOAD);
    assign w_is_store  = (r_opcode == OP_STORE);
    // Saturating wait counter; the limit is reached on the cycle whose
    // increment would land on TIMEOUT_CYCLES.
    assign w_cnt_next  = (r_cnt == LIMIT) ? r_cnt : r_cnt + CW'(1);
    assign w_limit_hit = (w_cnt_next == LIMIT);
    // next_state belongs to the interface contract but does not affect sequencing.
    assign w_unused_next = ^sm_if.next_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq          <= WAIT_ENTRY;
            r_cnt          <= '0;
            r_state_finish <= 1'b0;
            r_imem_req     <= 1'b0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_bus_err      <= 1'b0;
            r_opcode       <= OP_I_TYPE;
            r_instr        <= '0;
            r_load_data    <= '0;
        end else begin
            r_state_finish <= 1'b0;
            case (r_seq)
                WAIT_ENTRY: begin
                    if (w_entry) begin
                        case (sm_if.now_state)
                            FETCH, DECODE, EXECUTE, WRITEBACK: begin
                                r_seq      <= ACTIVE;
                                r_cnt      <= '0;
                                r_imem_req <= (sm_if.now_state == FETCH);
                            end
                            MEMORY: begin
                                // Non-memory opcodes complete without a request.
                                r_seq      <= ACTIVE;
                                r_cnt      <= '0;
                                r_dmem_req <= w_is_load || w_is_store;
                                r_dmem_we  <= w_is_store;
                            end
                            default: begin
                                r_seq     <= HALT;
                                r_bus_err <= 1'b1;
                            end
                        endcase
                    end
                end

                ACTIVE: begin
                    case (sm_if.now_state)
                        FETCH: begin
                            if (r_imem_req && i_imem_ready) begin
                                r_instr        <= i_imem_rdata;
                                r_imem_req     <= 1'b0;
                                r_seq          <= FINISH;
                                r_state_finish <= 1'b1;
                            end else if (w_limit_hit) begin
                                r_imem_req <= 1'b0;
                                r_bus_err  <= 1'b1;
                                r_cnt      <= w_cnt_next;
                                r_seq      <= HALT;
                            end else begin
                                r_cnt <= w_cnt_next;
                            end
                        end
                        DECODE: begin
                            r_opcode       <= r_instr[6:0];
                            r_seq          <= FINISH;
                            r_state_finish <= 1'b1;
                        end
                        EXECUTE: begin
                            if (!i_exec_stall) begin
                                r_seq          <= FINISH;
                                r_state_finish <= 1'b1;
                            end
                        end
                        MEMORY: begin
                            if (!r_dmem_req) begin
                                r_seq          <= FINISH;
                                r_state_finish <= 1'b1;
                            end else if (i_dmem_ready) begin
                                if (w_is_load) begin
                                    r_load_data <= i_dmem_rdata;
                                end
                                r_dmem_req     <= 1'b0;
                                r_dmem_we      <= 1'b0;
                                r_seq          <= FINISH;
                                r_state_finish <= 1'b1;
                            end else if (w_limit_hit) begin
                                r_dmem_req <= 1'b0;
                                r_dmem_we  <= 1'b0;
                                r_bus_err  <= 1'b1;
                                r_cnt      <= w_cnt_next;
                                r_seq      <= HALT;
                            end else begin
                                r_cnt <= w_cnt_next;
                            end
                        end
                        WRITEBACK: begin
                            r_seq          <= FINISH;
                            r_state_finish <= 1'b1;
                        end
                        default: begin
                            r_imem_req <= 1'b0;
                            r_dmem_req <= 1'b0;
                            r_bus_err  <= 1'b1;
                            r_seq      <= HALT;
                        end
                    endcase
                end

                FINISH: begin
                    r_seq <= WAIT_ENTRY;
                end

                HALT: begin
                    r_imem_req <= 1'b0;
                    r_dmem_req <= 1'b0;
                    r_bus_err  <= 1'b1;
                end

                default: begin
                    r_seq <= HALT;
                end
            endcase
        end
    end

    assign sm_if.state_finish = r_state_finish;
    assign sm_if.opcode       = r_opcode;
    assign o_imem_req         = r_imem_req;
    assign o_instr            = r_instr;
    assign o_dmem_req         = r_dmem_req;
    assign o_dmem_we          = r_dmem_we;
    assign o_load_data        = r_load_data;
    assign o_bus_err          = r_bus_err;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Drives stage_sequencer with a small model of state_machine plus instruction
// memory, data memory and execute-stall responders. Each instruction placed in
// the program queue also has its expected stage-finish records pushed into a
// scoreboard; a negedge monitor pops one record per state_finish pulse.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic [31:0] instr;
        int          ilat;
        int          k;
        int          dlat;
        logic [31:0] ddata;
    } item_t;

    typedef struct {
        state_t      stage;
        int          dur;
        logic [31:0] instr;
        logic [31:0] opcode;
        logic [31:0] ld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [31:0] load_data;
    logic        exec_stall = 1'b0;
    logic        bus_err;

    stage_sequencer_if sm_if ();

    stage_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .sm_if        (sm_if),
        .o_imem_req   (imem_req),
        .i_imem_ready (imem_ready),
        .i_imem_rdata (imem_rdata),
        .o_instr      (instr),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .i_dmem_ready (dmem_ready),
        .i_dmem_rdata (dmem_rdata),
        .o_load_data  (load_data),
        .i_exec_stall (exec_stall),
        .o_bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      passed = 0;
    int      cyc = 0;
    int      entry_cyc = 0;
    int      finishes = 0;
    int      ireq_cycles = 0;
    int      icnt = 0;
    int      dcnt = 0;
    int      eidx = 0;
    item_t   prog[$];
    exp_t    expq[$];
    item_t   cur;
    exp_t    e_m;
    logic    take = 1'b0;
    state_t  take_next = IDLE;
    opcode_t m_op = OP_I_TYPE;
    logic [31:0] m_ld = 32'h0;
    logic    cur_is_mem;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic legal(opcode_t op);
        return op inside {OP_LOAD, OP_STORE, OP_I_TYPE, OP_R_TYPE, OP_LUI};
    endfunction

    function automatic item_t idle_item();
        item_t it;
        it.instr = 32'h0000_0013;
        it.ilat  = 1000;
        it.k     = 0;
        it.dlat  = 1000;
        it.ddata = 32'h0;
        return it;
    endfunction

    // state_machine transition rules
    always_comb begin
        sm_if.next_state = IDLE;
        case (sm_if.now_state)
            FETCH:     sm_if.next_state = DECODE;
            DECODE:    sm_if.next_state = legal(sm_if.opcode) ? EXECUTE : IDLE;
            EXECUTE:   sm_if.next_state = (sm_if.opcode == OP_LOAD || sm_if.opcode == OP_STORE)
                                          ? MEMORY : WRITEBACK;
            MEMORY:    sm_if.next_state = (sm_if.opcode == OP_LOAD) ? WRITEBACK : FETCH;
            WRITEBACK: sm_if.next_state = FETCH;
            default:   sm_if.next_state = IDLE;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void push_exp(state_t st, int dur, logic [31:0] ins);
        exp_t e;
        e.stage  = st;
        e.dur    = dur;
        e.instr  = ins;
        e.opcode = 32'(m_op);
        e.ld     = m_ld;
        expq.push_back(e);
    endfunction

    // Reference: each stage lasts entry..finish = 2 + (wait cycles) cycles.
    function automatic void model_instr(item_t it, logic stop_at_mem);
        opcode_t op;
        op = it.instr[6:0];
        push_exp(FETCH, it.ilat + 2, it.instr);
        m_op = op;
        push_exp(DECODE, 2, it.instr);
        if (!legal(op)) return;
        push_exp(EXECUTE, it.k + 2, it.instr);
        if (stop_at_mem) return;
        if (op == OP_LOAD) begin
            m_ld = it.ddata;
            push_exp(MEMORY, it.dlat + 2, it.instr);
            push_exp(WRITEBACK, 2, it.instr);
        end else if (op == OP_STORE) begin
            push_exp(MEMORY, it.dlat + 2, it.instr);
        end else begin
            push_exp(WRITEBACK, 2, it.instr);
        end
    endfunction

    task automatic add_item(input logic [31:0] ins, input int ilat, input int k,
                            input int dlat, input logic [31:0] dd, input logic do_model);
        item_t it;
        it.instr = ins;
        it.ilat  = ilat;
        it.k     = k;
        it.dlat  = dlat;
        it.ddata = dd;
        prog.push_back(it);
        if (do_model) model_instr(it, 1'b0);
    endtask

    task automatic model_reset();
        m_op = OP_I_TYPE;
        m_ld = 32'h0;
    endtask

    // One clock: update state_machine model and responders just after the edge.
    task automatic tick();
        logic   new_take;
        state_t new_next;
        @(posedge clk);
        #1;
        new_take = sm_if.state_finish;
        new_next = sm_if.next_state;
        if (rst) begin
            sm_if.now_state    = FETCH;
            sm_if.now_state_d1 = IDLE;
            take = 1'b0;
        end else begin
            sm_if.now_state_d1 = sm_if.now_state;
            if (take) sm_if.now_state = take_next;
            take      = new_take;
            take_next = new_next;
        end

        if (imem_req) begin
            if (icnt == 0) cur = (prog.size() > 0) ? prog.pop_front() : idle_item();
            if (icnt == cur.ilat) begin
                imem_ready = 1'b1;
                imem_rdata = cur.instr;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
            end
            icnt++;
            ireq_cycles++;
        end else begin
            icnt = 0;
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end

        if (dmem_req) begin
            if (dcnt == cur.dlat) begin
                dmem_ready = 1'b1;
                dmem_rdata = cur.ddata;
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = $urandom;
            end
            dcnt++;
        end else begin
            dcnt = 0;
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end

        if (sm_if.now_state == EXECUTE) begin
            if (sm_if.now_state_d1 != EXECUTE) eidx = 0;
            else eidx++;
            if (eidx == 0) exec_stall = 1'($urandom_range(0, 1));
            else exec_stall = (eidx <= cur.k);
        end else begin
            exec_stall = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        prog.delete();
        expq.delete();
        cur = idle_item();
        ireq_cycles = 0;
        model_reset();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (expq.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_scoreboard_empty", 32'(expq.size()), 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (sm_if.now_state != sm_if.now_state_d1) entry_cyc = cyc;
            if (sm_if.state_finish) begin
                finishes++;
                if (expq.size() == 0) begin
                    check("unexpected_finish", 32'(sm_if.now_state), 32'hFFFF_FFFF);
                end else begin
                    e_m = expq.pop_front();
                    check("finish_stage",     32'(sm_if.now_state), 32'(e_m.stage));
                    check("finish_duration",  32'(cyc - entry_cyc), 32'(e_m.dur));
                    check("finish_instr",     instr, e_m.instr);
                    check("finish_opcode",    32'(sm_if.opcode), e_m.opcode);
                    check("finish_load_data", load_data, e_m.ld);
                    check("finish_bus_err",   32'(bus_err), 32'h0);
                end
            end
            if (dmem_req) begin
                cur_is_mem = (cur.instr[6:0] == OP_LOAD) || (cur.instr[6:0] == OP_STORE);
                if (!cur_is_mem) check("dmem_req_non_mem_op", 32'(dmem_req), 32'h0);
                check("dmem_we", 32'(dmem_we), 32'(cur.instr[6:0] == OP_STORE));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] rnd;
        opcode_t     ops[5];
        int          n;
        int          f0;

        ops[0] = OP_R_TYPE; ops[1] = OP_I_TYPE; ops[2] = OP_LOAD;
        ops[3] = OP_STORE;  ops[4] = OP_LUI;
        sm_if.now_state    = FETCH;
        sm_if.now_state_d1 = IDLE;
        cur = idle_item();
        rst = 1'b1;
        repeat (3) tick();

        check("rst_imem_req",     32'(imem_req), 32'h0);
        check("rst_dmem_req",     32'(dmem_req), 32'h0);
        check("rst_dmem_we",      32'(dmem_we), 32'h0);
        check("rst_instr",        instr, 32'h0);
        check("rst_load_data",    load_data, 32'h0);
        check("rst_bus_err",      32'(bus_err), 32'h0);
        check("rst_opcode",       32'(sm_if.opcode), 32'(OP_I_TYPE));
        check("rst_state_finish", 32'(sm_if.state_finish), 32'h0);

        // Directed program followed by randomized instructions
        model_reset();
        add_item(32'h002081B3, 2, 0, 0, 32'h0, 1'b1);
        add_item(32'h0000A183, 1, 0, 3, 32'hDEADBEEF, 1'b1);
        add_item(32'h0020A023, 0, 0, 0, 32'h0, 1'b1);
        add_item(32'h002081B3, 0, 5, 0, 32'h0, 1'b1);
        add_item(32'h002081B3, 0, 0, 0, 32'h0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            rnd = $urandom;
            add_item({rnd[31:7], ops[$urandom_range(0, 4)]},
                     $urandom_range(0, 6),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                     $urandom_range(0, 6),
                     $urandom, 1'b1);
        end
        rst = 1'b0;
        drain(4000);
        check("final_load_data", load_data, m_ld);
        check("final_bus_err", 32'(bus_err), 32'h0);

        // Timeout: imem never answers in time
        do_reset();
        add_item(32'h002081B3, TO, 0, 0, 32'h0, 1'b0);
        rst = 1'b0;
        n = 0;
        while (!bus_err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_bus_err", 32'(bus_err), 32'h1);
        check("timeout_req_cycles", 32'(ireq_cycles), 32'(TO));
        f0 = finishes;
        repeat (10) tick();
        check("halt_imem_req", 32'(imem_req), 32'h0);
        check("halt_no_finish", 32'(finishes), 32'(f0));
        check("halt_bus_err_sticky", 32'(bus_err), 32'h1);

        // Recovery: ready arrives on the last allowed cycle
        do_reset();
        check("recover_bus_err_clear", 32'(bus_err), 32'h0);
        add_item(32'h002081B3, TO - 1, 0, 0, 32'h0, 1'b1);
        rst = 1'b0;
        drain(200);
        check("limit_ready_bus_err", 32'(bus_err), 32'h0);

        // Illegal instruction sends state_machine to IDLE
        do_reset();
        add_item(32'h0000007F, 1, 0, 0, 32'h0, 1'b1);
        rst = 1'b0;
        drain(200);
        f0 = finishes;
        repeat (6) tick();
        check("illegal_bus_err", 32'(bus_err), 32'h1);
        check("illegal_imem_req", 32'(imem_req), 32'h0);
        check("illegal_opcode", 32'(sm_if.opcode), 32'h7F);
        check("illegal_no_finish", 32'(finishes), 32'(f0));

        // Reset while a load waits in MEMORY
        do_reset();
        prog.push_back('{32'h0000A183, 0, 0, 10, 32'h12345678});
        model_instr('{32'h0000A183, 0, 0, 10, 32'h12345678}, 1'b1);
        rst = 1'b0;
        drain(200);
        n = 0;
        while (!dmem_req && n < 20) begin
            tick();
            n++;
        end
        check("mem_wait_req_seen", 32'(dmem_req), 32'h1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mrst_dmem_req",     32'(dmem_req), 32'h0);
        check("mrst_dmem_we",      32'(dmem_we), 32'h0);
        check("mrst_imem_req",     32'(imem_req), 32'h0);
        check("mrst_instr",        instr, 32'h0);
        check("mrst_load_data",    load_data, 32'h0);
        check("mrst_opcode",       32'(sm_if.opcode), 32'(OP_I_TYPE));
        check("mrst_bus_err",      32'(bus_err), 32'h0);
        check("mrst_state_finish", 32'(sm_if.state_finish), 32'h0);
        repeat (12) tick();
        check("mrst_load_data_hold", load_data, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
